// File: rtl/tea_stream_pkg.sv
// Shared definitions for the TEA stream arbiter: channel ids, FSM states, data width.
package tea_stream_pkg;

  localparam int DW = 64;

  localparam logic CH_ENC = 1'b0;
  localparam logic CH_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/tea_stream_outreg.sv
// One-entry AXI-Stream output register with a wrapping count of delivered beats.
module tea_stream_outreg #(
  parameter int DW    = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [DW-1:0]    i_data,
  input  logic             i_last,
  input  logic             i_tready,
  output logic [DW-1:0]    o_tdata,
  output logic             o_tvalid,
  output logic             o_tlast,
  output logic [CNT_W-1:0] o_cnt
);

  logic [DW-1:0]    r_data;
  logic             r_valid;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign w_drain  = r_valid & i_tready;
  assign o_tdata  = r_data;
  assign o_tvalid = r_valid;
  assign o_tlast  = r_last;
  assign o_cnt    = r_cnt;

  // Hold a result until the consumer takes it; a load never coincides with a drain.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_drain) begin
        r_valid <= 1'b0;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (i_load) begin
        r_data  <= i_data;
        r_last  <= i_last;
        r_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tea_stream_arbiter.sv
// Shares one iterative TEA core between an encrypt stream (ch0) and a decrypt stream (ch1).
module tea_stream_arbiter #(
  parameter int DW         = 64,
  parameter int LOCK_FRAME = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DW-1:0]    s0_tdata,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [DW-1:0]    s1_tdata,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  output logic [DW-1:0]    m0_tdata,
  output logic             m0_tvalid,
  output logic             m0_tlast,
  input  logic             m0_tready,
  output logic [DW-1:0]    m1_tdata,
  output logic             m1_tvalid,
  output logic             m1_tlast,
  input  logic             m1_tready,
  output logic             core_start,
  output logic             core_mode,
  output logic [DW-1:0]    core_din,
  input  logic             core_done,
  input  logic [DW-1:0]    core_dout,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  import tea_stream_pkg::*;

  localparam logic LOCK_EN = (LOCK_FRAME != 0);

  state_t        r_state;
  state_t        w_next;
  logic          r_rr;
  logic          r_lock;
  logic          r_lockCh;
  logic          r_ch;
  logic          r_last;
  logic [DW-1:0] r_din;

  logic          w_elig0;
  logic          w_elig1;
  logic          w_grant;
  logic          w_gntCh;
  logic          w_done;

  assign w_elig0   = s0_tvalid & ~m0_tvalid;
  assign w_elig1   = s1_tvalid & ~m1_tvalid;
  assign w_done    = (r_state == ST_WAIT) & core_done;
  assign s0_tready = w_grant & (w_gntCh == CH_ENC);
  assign s1_tready = w_grant & (w_gntCh == CH_DEC);
  assign core_din  = r_din;
  assign core_mode = r_ch;
  assign busy      = (r_state != ST_IDLE);

  // Arbitration and sequencing; grants are suppressed while reset is held so no beat is lost.
  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_gntCh    = CH_ENC;
    core_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_lock) begin
          w_gntCh = r_lockCh;
          w_grant = r_lockCh ? w_elig1 : w_elig0;
        end else if (w_elig0 & w_elig1) begin
          w_gntCh = r_rr;
          w_grant = 1'b1;
        end else if (w_elig0) begin
          w_gntCh = CH_ENC;
          w_grant = 1'b1;
        end else if (w_elig1) begin
          w_gntCh = CH_DEC;
          w_grant = 1'b1;
        end
        w_grant = w_grant & resetn;
        if (w_grant) w_next = ST_START;
      end
      ST_START: begin
        core_start = 1'b1;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, captured operand, and round-robin/frame-lock bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_rr     <= 1'b0;
      r_lock   <= 1'b0;
      r_lockCh <= 1'b0;
      r_ch     <= 1'b0;
      r_last   <= 1'b0;
      r_din    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_ch   <= w_gntCh;
        r_din  <= w_gntCh ? s1_tdata : s0_tdata;
        r_last <= w_gntCh ? s1_tlast : s0_tlast;
      end
      if (w_done) begin
        r_rr     <= ~r_ch;
        r_lock   <= LOCK_EN & ~r_last;
        r_lockCh <= r_ch;
      end
    end
  end

  tea_stream_outreg #(.DW(DW), .CNT_W(CNT_W)) u_out0 (
    .clk      (clk),
    .resetn   (resetn),
    .i_load   (w_done & (r_ch == CH_ENC)),
    .i_data   (core_dout),
    .i_last   (r_last),
    .i_tready (m0_tready),
    .o_tdata  (m0_tdata),
    .o_tvalid (m0_tvalid),
    .o_tlast  (m0_tlast),
    .o_cnt    (cnt0)
  );

  tea_stream_outreg #(.DW(DW), .CNT_W(CNT_W)) u_out1 (
    .clk      (clk),
    .resetn   (resetn),
    .i_load   (w_done & (r_ch == CH_DEC)),
    .i_data   (core_dout),
    .i_last   (r_last),
    .i_tready (m1_tready),
    .o_tdata  (m1_tdata),
    .o_tvalid (m1_tvalid),
    .o_tlast  (m1_tlast),
    .o_cnt    (cnt1)
  );

endmodule

// File: tb/tb_tea_stream_arbiter.sv
// Directed bench: instance 0 re-arbitrates per beat, instance 1 locks per frame; both CNT_W=4.
module tb_tea_stream_arbiter;

  logic clk;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] sTdata  [2][2];
  logic        sTvalid [2][2];
  logic        sTlast  [2][2];
  logic        sTready [2][2];
  logic [63:0] mTdata  [2][2];
  logic        mTvalid [2][2];
  logic        mTlast  [2][2];
  logic        mTready [2][2];
  logic [3:0]  cnt     [2][2];
  logic        coreStart [2];
  logic        coreMode  [2];
  logic [63:0] coreDin   [2];
  logic        coreDone  [2];
  logic [63:0] coreDout  [2];
  logic        busy      [2];

  logic        coreAct [2] = '{1'b0, 1'b0};
  logic [5:0]  coreCnt [2] = '{6'd0, 6'd0};
  logic [63:0] coreRes [2] = '{64'd0, 64'd0};

  logic [63:0] rx [2][2][64];
  int          rxCnt [2][2] = '{'{0, 0}, '{0, 0}};
  logic        grantLog [2][64];
  int          grantCnt [2] = '{0, 0};

  int t0, t1, tA, seen, n, r0, r1, g0;
  logic stray;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    tea_stream_arbiter #(.DW(64), .LOCK_FRAME(g), .CNT_W(4)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .s0_tdata   (sTdata[g][0]),
      .s0_tvalid  (sTvalid[g][0]),
      .s0_tlast   (sTlast[g][0]),
      .s0_tready  (sTready[g][0]),
      .s1_tdata   (sTdata[g][1]),
      .s1_tvalid  (sTvalid[g][1]),
      .s1_tlast   (sTlast[g][1]),
      .s1_tready  (sTready[g][1]),
      .m0_tdata   (mTdata[g][0]),
      .m0_tvalid  (mTvalid[g][0]),
      .m0_tlast   (mTlast[g][0]),
      .m0_tready  (mTready[g][0]),
      .m1_tdata   (mTdata[g][1]),
      .m1_tvalid  (mTvalid[g][1]),
      .m1_tlast   (mTlast[g][1]),
      .m1_tready  (mTready[g][1]),
      .core_start (coreStart[g]),
      .core_mode  (coreMode[g]),
      .core_din   (coreDin[g]),
      .core_done  (coreDone[g]),
      .core_dout  (coreDout[g]),
      .busy       (busy[g]),
      .cnt0       (cnt[g][0]),
      .cnt1       (cnt[g][1])
    );
    assign coreDone[g] = coreAct[g] && (coreCnt[g] == 6'd0);
    assign coreDout[g] = coreRes[g];
  end

  // Core model: done pulses 32 cycles after start; it ignores DUT reset on purpose.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (coreStart[k]) begin
        coreAct[k] <= 1'b1;
        coreCnt[k] <= 6'd31;
        coreRes[k] <= coreMode[k] ? coreDin[k] - 64'd1 : coreDin[k] + 64'd1;
      end else if (coreAct[k]) begin
        if (coreCnt[k] == 6'd0) coreAct[k] <= 1'b0;
        else coreCnt[k] <= coreCnt[k] - 6'd1;
      end
    end
  end

  // Record delivered beats and the channel order of core starts.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (mTvalid[k][c] && mTready[k][c]) begin
          rx[k][c][rxCnt[k][c] & 63] <= mTdata[k][c];
          rxCnt[k][c] <= rxCnt[k][c] + 1;
        end
      end
      if (coreStart[k]) begin
        grantLog[k][grantCnt[k] & 63] <= coreMode[k];
        grantCnt[k] <= grantCnt[k] + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Present one beat starting at a negedge and hold it until accepted (bounded).
  task automatic applyStimulus(input int k, input int c, input logic [63:0] data, input logic last,
                               output int accCyc);
    int waited;
    sTdata[k][c]  = data;
    sTlast[k][c]  = last;
    sTvalid[k][c] = 1'b1;
    accCyc = -1;
    waited = 0;
    #1;
    while (!sTready[k][c] && waited < 2000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (sTready[k][c]) begin
      accCyc = cyc;
      @(negedge clk);
    end else begin
      checkOutput("acceptTimeout", 64'd0, 64'd1);
    end
    sTvalid[k][c] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        sTdata[k][c]  = '0;
        sTvalid[k][c] = 1'b0;
        sTlast[k][c]  = 1'b0;
        mTready[k][c] = 1'b1;
      end
    end
    mTready[0][0] = 1'b0;
    sTvalid[0][1] = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state, with a request pending on ch1 that must not be accepted.
    checkOutput("rstTready1", sTready[0][1], 0);
    checkOutput("rstBusy", busy[0], 0);
    checkOutput("rstStart", coreStart[0], 0);
    checkOutput("rstMvalid0", mTvalid[0][0], 0);
    checkOutput("rstCnt0", cnt[0][0], 0);
    checkOutput("rstDin", coreDin[0], 0);
    sTvalid[0][1] = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    // Single encrypt beat: 5 -> 6 with tlast, latency 34 from acceptance.
    applyStimulus(0, 0, 64'h5, 1'b1, tA);
    n = 0;
    while (!mTvalid[0][0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    seen = cyc;
    checkOutput("latency", seen - tA, 34);
    checkOutput("singleData", mTdata[0][0], 64'h6);
    checkOutput("singleLast", mTlast[0][0], 1);
    checkOutput("ch1Untouched", mTvalid[0][1], 0);
    mTready[0][0] = 1'b1;
    @(negedge clk);
    checkOutput("singleDrained", mTvalid[0][0], 0);
    checkOutput("singleCnt0", cnt[0][0], 1);
    checkOutput("singleCnt1", cnt[0][1], 0);

    // Both channels busy, per-beat round robin; rr points at ch1 after the single beat.
    g0 = grantCnt[0];
    r0 = rxCnt[0][0];
    r1 = rxCnt[0][1];
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 64'd100 + 64'(i), 1'b0, t0);
      end
      begin
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 64'd200 + 64'(i), i == 3, t1);
      end
    join
    repeat (40) @(negedge clk);
    for (int i = 0; i < 8; i++) checkOutput("rrGrant", 64'(grantLog[0][(g0 + i) & 63]), (i % 2 == 0) ? 1 : 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rrData0", rx[0][0][(r0 + i) & 63], 64'd101 + 64'(i));
      checkOutput("rrData1", rx[0][1][(r1 + i) & 63], 64'd199 + 64'(i));
    end
    checkOutput("rrCnt0", cnt[0][0], 5);
    checkOutput("rrCnt1", cnt[0][1], 4);

    // Backpressure on m0 for 200 cycles; ch1 keeps flowing.
    mTready[0][0] = 1'b0;
    r0 = rxCnt[0][0];
    r1 = rxCnt[0][1];
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 64'd300 + 64'(i), 1'b0, t0);
      end
      begin
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 64'd400 + 64'(i), 1'b0, t1);
      end
      begin
        repeat (200) @(negedge clk);
        checkOutput("bpHeldValid", mTvalid[0][0], 1);
        checkOutput("bpHeldData", mTdata[0][0], 64'd301);
        checkOutput("bpCh1Flow", 64'(rxCnt[0][1] - r1), 4);
        checkOutput("bpCh0None", 64'(rxCnt[0][0] - r0), 0);
        mTready[0][0] = 1'b1;
      end
    join
    repeat (40) @(negedge clk);
    for (int i = 0; i < 3; i++) checkOutput("bpData0", rx[0][0][(r0 + i) & 63], 64'd301 + 64'(i));
    for (int i = 0; i < 4; i++) checkOutput("bpData1", rx[0][1][(r1 + i) & 63], 64'd399 + 64'(i));
    checkOutput("bpCnt0", cnt[0][0], 8);
    checkOutput("bpCnt1", cnt[0][1], 8);

    // Frame lock on instance 1: ch0 three-beat frame must finish before ch1 is served.
    g0 = grantCnt[1];
    r0 = rxCnt[1][0];
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 64'd500 + 64'(i), i == 2, t0);
      end
      begin
        for (int i = 0; i < 2; i++) applyStimulus(1, 1, 64'd600 + 64'(i), 1'b1, t1);
      end
    join
    repeat (40) @(negedge clk);
    for (int i = 0; i < 5; i++) checkOutput("lockGrant", 64'(grantLog[1][(g0 + i) & 63]), (i < 3) ? 0 : 1);
    for (int i = 0; i < 3; i++) checkOutput("lockData0", rx[1][0][(r0 + i) & 63], 64'd501 + 64'(i));
    checkOutput("lockCnt0", cnt[1][0], 3);
    checkOutput("lockCnt1", cnt[1][1], 2);

    // Reset during WAIT: outputs clear, the late done is ignored, next beat is normal.
    applyStimulus(0, 0, 64'h77, 1'b1, tA);
    repeat (5) @(negedge clk);
    checkOutput("midBusy", busy[0], 1);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("rst2Busy", busy[0], 0);
    checkOutput("rst2Start", coreStart[0], 0);
    checkOutput("rst2Mode", coreMode[0], 0);
    checkOutput("rst2Din", coreDin[0], 0);
    checkOutput("rst2Mvalid0", mTvalid[0][0], 0);
    checkOutput("rst2Mdata0", mTdata[0][0], 0);
    checkOutput("rst2Cnt0", cnt[0][0], 0);
    checkOutput("rst2Cnt1", cnt[0][1], 0);
    resetn = 1'b1;
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (mTvalid[0][0] || mTvalid[0][1] || busy[0]) stray = 1'b1;
    end
    checkOutput("strayDone", stray, 0);
    r0 = rxCnt[0][0];
    applyStimulus(0, 0, 64'h10, 1'b1, tA);
    repeat (40) @(negedge clk);
    checkOutput("postRstData", rx[0][0][r0 & 63], 64'h11);
    checkOutput("postRstCnt0", cnt[0][0], 1);

    // 18 decrypt beats on ch1 wrap the 4-bit counter to 2; includes a borrow from zero.
    r1 = rxCnt[0][1];
    for (int i = 0; i < 18; i++) applyStimulus(0, 1, 64'h1_0000_0001 * 64'(i), i == 17, t1);
    repeat (40) @(negedge clk);
    checkOutput("wrapCount", 64'(rxCnt[0][1] - r1), 18);
    for (int i = 0; i < 18; i++)
      checkOutput("wrapData", rx[0][1][(r1 + i) & 63], 64'h1_0000_0001 * 64'(i) - 64'd1);
    checkOutput("wrapCnt1", cnt[0][1], 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
